// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types and helpers for the crossbar slave route lock
//
// Purpose: route-lock state encoding and the outstanding-request limit
//          derived from LGMAXBURST.
// Ports:   none (package).
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } route_state_t;

  function automatic int max_outstanding(input int lgmaxburst);
    return 1 << lgmaxburst;
  endfunction

endpackage

// File: rtl/outstanding_ctr.sv
// rtl/outstanding_ctr.sv - up/down outstanding-request counter with zero/full flags
//
// Purpose: counts requests issued but not yet acknowledged.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_inc              one request issued this cycle
//   i_dec              one response returned this cycle (ignored at zero)
//   o_count            current count, 0..2^LGMAXBURST
//   o_full             count == 2^LGMAXBURST
//   o_zero             count == 0
module outstanding_ctr
  import xbar_pkg::*;
#(
  parameter int LGMAXBURST = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_inc,
  input  logic                  i_dec,
  output logic [LGMAXBURST:0]   o_count,
  output logic                  o_full,
  output logic                  o_zero
);

  localparam int                MAX       = max_outstanding(LGMAXBURST);
  localparam logic [LGMAXBURST:0] MAX_COUNT = (LGMAXBURST+1)'(MAX);
  localparam logic [LGMAXBURST:0] ONE       = (LGMAXBURST+1)'(1);

  logic dec_eff;
  logic inc_eff;

  // An ack with nothing outstanding is a protocol violation: drop it so the
  // count never wraps below zero.
  assign dec_eff = i_dec && !o_zero;
  // Never count past MAX unless a response frees a slot in the same cycle.
  assign inc_eff = i_inc && (!o_full || dec_eff);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_count <= '0;
    end else if (inc_eff && !dec_eff) begin
      o_count <= o_count + ONE;
    end else if (dec_eff && !inc_eff) begin
      o_count <= o_count - ONE;
    end
  end

  assign o_full = (o_count == MAX_COUNT);
  assign o_zero = (o_count == '0);

endmodule

// File: rtl/slave_route_lock.sv
// rtl/slave_route_lock.sv - locks a master channel to one slave while responses are outstanding
//
// Purpose: sits after the crossbar address decoder. Routed requests are
//          registered and forwarded; a request to a different slave waits
//          until every outstanding response has drained. None-selected
//          requests are answered in order with a one-cycle local bus error.
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   i_valid/o_stall         upstream request handshake (o_stall combinational)
//   i_decode[NS:0]          one-hot decode, bit NS = none-selected
//   i_addr, i_data          request payload
//   o_valid/i_stall         downstream request handshake (o_valid registered)
//   o_sel, o_addr, o_data   registered downstream request
//   i_ack                   one response from the locked slave
//   o_err                   one-cycle bus error for a none-selected request
//   o_outstanding           outstanding response count
//   o_idle                  nothing outstanding, nothing pending, no error
module slave_route_lock
  import xbar_pkg::*;
#(
  parameter int NS           = 8,
  parameter int AW           = 32,
  parameter int DW           = 38,
  parameter int LGMAXBURST   = 6,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_valid,
  output logic                o_stall,
  input  logic [NS:0]         i_decode,
  input  logic [AW-1:0]       i_addr,
  input  logic [DW-1:0]       i_data,
  output logic                o_valid,
  input  logic                i_stall,
  output logic [NS-1:0]       o_sel,
  output logic [AW-1:0]       o_addr,
  output logic [DW-1:0]       o_data,
  input  logic                i_ack,
  output logic                o_err,
  output logic [LGMAXBURST:0] o_outstanding,
  output logic                o_idle
);

  localparam logic [LGMAXBURST:0] ONE = (LGMAXBURST+1)'(1);

  route_state_t           state;
  logic [NS-1:0]          lock_sel;
  logic [NS-1:0]          req_sel;
  logic                   decode_none;
  logic                   routed;
  logic                   none_sel;
  logic                   accept;
  logic                   routed_acc;
  logic                   none_acc;
  logic                   ctr_full;
  logic                   ctr_zero;
  logic                   last_ack;

  assign req_sel = i_decode[NS-1:0];
  // An empty decode or the explicit none-selected bit both mean "no slave";
  // a malformed decode carrying the none bit is answered with an error too.
  assign decode_none = i_decode[NS] || (req_sel == '0);
  assign routed      = i_valid && !decode_none;
  assign none_sel    = i_valid && decode_none;

  assign o_stall = (o_valid && i_stall)
                || (state == ERR)
                || (ctr_full && !i_ack)
                || (!ctr_zero && routed && (req_sel != lock_sel))
                || (none_sel && (!ctr_zero || o_valid));

  assign accept     = i_valid && !o_stall;
  assign routed_acc = accept && !decode_none;
  assign none_acc   = accept && decode_none;

  outstanding_ctr #(
    .LGMAXBURST (LGMAXBURST)
  ) u_ctr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (routed_acc),
    .i_dec     (i_ack),
    .o_count   (o_outstanding),
    .o_full    (ctr_full),
    .o_zero    (ctr_zero)
  );

  // The final response drains the lock unless a new request takes its place.
  assign last_ack = (o_outstanding == ONE) && i_ack && !routed_acc;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      lock_sel <= '0;
      o_err    <= 1'b0;
      o_valid  <= 1'b0;
      o_sel    <= '0;
      o_addr   <= '0;
      o_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (routed_acc) begin
            state <= BUSY;
          end else if (none_acc) begin
            state <= ERR;
          end
        end
        BUSY: begin
          if (last_ack) begin
            state <= IDLE;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase

      o_err <= none_acc;

      if (routed_acc) begin
        lock_sel <= req_sel;
      end

      if (routed_acc) begin
        o_valid <= 1'b1;
        o_sel   <= req_sel;
        o_addr  <= i_addr;
        o_data  <= i_data;
      end else if (!(o_valid && i_stall)) begin
        o_valid <= 1'b0;
        if (OPT_LOWPOWER) begin
          o_sel  <= '0;
          o_addr <= '0;
          o_data <= '0;
        end
      end
    end
  end

  assign o_idle = ctr_zero && !o_valid && !o_err;

endmodule

// File: tb/tb_slave_route_lock.sv
// tb/tb_slave_route_lock.sv - randomized self-checking bench for slave_route_lock
module tb_slave_route_lock;

  localparam int NS  = 8;
  localparam int AW  = 32;
  localparam int DW  = 38;
  localparam int LG  = 2;
  localparam int MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_valid;
  logic          o_stall;
  logic [NS:0]   i_decode;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_stall;
  logic [NS-1:0] o_sel;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          i_ack;
  logic          o_err;
  logic [LG:0]   o_outstanding;
  logic          o_idle;

  slave_route_lock #(
    .NS           (NS),
    .AW           (AW),
    .DW           (DW),
    .LGMAXBURST   (LG),
    .OPT_LOWPOWER (1'b1)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_valid       (i_valid),
    .o_stall       (o_stall),
    .i_decode      (i_decode),
    .i_addr        (i_addr),
    .i_data        (i_data),
    .o_valid       (o_valid),
    .i_stall       (i_stall),
    .o_sel         (o_sel),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .i_ack         (i_ack),
    .o_err         (o_err),
    .o_outstanding (o_outstanding),
    .o_idle        (o_idle)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the channel should look like, tracked as plain
  // counts and the most recently forwarded request.
  int            m_cnt;
  logic [NS-1:0] m_lock;
  logic          m_valid;
  logic [NS-1:0] m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_err;

  task automatic model_reset();
    m_cnt   = 0;
    m_lock  = '0;
    m_valid = 1'b0;
    m_sel   = '0;
    m_addr  = '0;
    m_data  = '0;
    m_err   = 1'b0;
  endtask

  function automatic logic model_stall(input logic v, input logic [NS:0] dec,
                                       input logic st, input logic ak);
    logic none;
    none = dec[NS] || (dec[NS-1:0] == '0);
    if (m_err) return 1'b1;
    if (m_valid && st) return 1'b1;
    if (m_cnt == MAX && !ak) return 1'b1;
    if (v && !none && m_cnt != 0 && dec[NS-1:0] != m_lock) return 1'b1;
    if (v && none && (m_cnt != 0 || m_valid)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic v, input logic [NS:0] dec, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic st, input logic ak,
                      input logic rn, output logic acc);
    logic exp_stall;
    logic none;
    int   dec_n;
    @(negedge clk);
    check_eq("o_valid", 64'(o_valid), 64'(m_valid));
    check_eq("o_sel", 64'(o_sel), 64'(m_sel));
    check_eq("o_addr", 64'(o_addr), 64'(m_addr));
    check_eq("o_data", 64'(o_data), 64'(m_data));
    check_eq("o_err", 64'(o_err), 64'(m_err));
    check_eq("o_outstanding", 64'(o_outstanding), 64'(m_cnt));
    check_eq("o_idle", 64'(o_idle), 64'(m_cnt == 0 && !m_valid && !m_err));
    i_valid  = v;
    i_decode = dec;
    i_addr   = a;
    i_data   = d;
    i_stall  = st;
    i_ack    = ak;
    rst_n    = rn;
    #1;
    exp_stall = model_stall(v, dec, st, ak);
    if (rn) check_eq("o_stall", 64'(o_stall), 64'(exp_stall));
    acc = rn && v && !exp_stall;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      none  = dec[NS] || (dec[NS-1:0] == '0);
      dec_n = (ak && m_cnt > 0) ? 1 : 0;
      m_cnt = m_cnt + ((acc && !none) ? 1 : 0) - dec_n;
      m_err = acc && none;
      if (acc && !none) begin
        m_lock  = dec[NS-1:0];
        m_valid = 1'b1;
        m_sel   = dec[NS-1:0];
        m_addr  = a;
        m_data  = d;
      end else if (!(m_valid && st)) begin
        m_valid = 1'b0;
        m_sel   = '0;
        m_addr  = '0;
        m_data  = '0;
      end
    end
  endtask

  logic          acc;
  logic [NS:0]   rdec;
  logic [DW-1:0] rdata;

  initial begin
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_decode = '0;
    i_addr   = '0;
    i_data   = '0;
    i_stall  = 1'b0;
    i_ack    = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check_eq("rst_idle", 64'(o_idle), 64'(1));
    check_eq("rst_valid", 64'(o_valid), 64'(0));

    // Three back-to-back requests to slave 2.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9'h004, 32'h1000 + 32'(i), 38'(i + 7), 1'b0, 1'b0, 1'b1, acc);
      check_eq("burst_acc", 64'(acc), 64'(1));
      #1;
      check_eq("burst_sel", 64'(o_sel), 64'(8'h04));
    end
    check_eq("burst_cnt", 64'(o_outstanding), 64'(3));

    // Lock holds slave 5 off until slave 2 drains.
    step(1'b0, 9'h000, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 9'h020, 32'h2000, 38'h5, 1'b0, 1'b0, 1'b1, acc);
    check_eq("other_slave_stall", 64'(acc), 64'(0));
    step(1'b1, 9'h020, 32'h2000, 38'h5, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 9'h020, 32'h2000, 38'h5, 1'b0, 1'b1, 1'b1, acc);
    check_eq("drain_stall", 64'(acc), 64'(0));
    step(1'b1, 9'h020, 32'h2000, 38'h5, 1'b0, 1'b0, 1'b1, acc);
    check_eq("relock_acc", 64'(acc), 64'(1));
    #1;
    check_eq("relock_sel", 64'(o_sel), 64'(8'h20));

    // None-selected waits for the drain, then errors for exactly one cycle.
    step(1'b1, 9'h100, 32'h3000, 38'h0, 1'b0, 1'b0, 1'b1, acc);
    check_eq("none_busy_stall", 64'(acc), 64'(0));
    step(1'b1, 9'h100, 32'h3000, 38'h0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 9'h100, 32'h3000, 38'h0, 1'b0, 1'b0, 1'b1, acc);
    check_eq("none_acc", 64'(acc), 64'(1));
    #1;
    check_eq("err_pulse", 64'(o_err), 64'(1));
    check_eq("err_no_fwd", 64'(o_valid), 64'(0));
    step(1'b0, 9'h000, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    #1;
    check_eq("err_one_cycle", 64'(o_err), 64'(0));
    check_eq("err_back_idle", 64'(o_idle), 64'(1));

    // Ack with nothing outstanding is ignored.
    step(1'b0, 9'h000, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    #1;
    check_eq("stray_ack", 64'(o_outstanding), 64'(0));

    // Fill to MAX; the extra request only enters alongside an ack.
    for (int i = 0; i < MAX; i++) begin
      step(1'b1, 9'h002, 32'h4000 + 32'(i), 38'(i), 1'b0, 1'b0, 1'b1, acc);
    end
    step(1'b1, 9'h002, 32'h4100, 38'h1, 1'b0, 1'b0, 1'b1, acc);
    check_eq("full_stall", 64'(acc), 64'(0));
    step(1'b1, 9'h002, 32'h4100, 38'h1, 1'b0, 1'b1, 1'b1, acc);
    check_eq("full_ack_acc", 64'(acc), 64'(1));
    #1;
    check_eq("full_cnt", 64'(o_outstanding), 64'(MAX));
    for (int i = 0; i < MAX; i++) begin
      step(1'b0, 9'h000, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    end
    #1;
    check_eq("lowpower_zero", 64'(o_addr), 64'(0));

    // Downstream stall holds the registered request.
    step(1'b1, 9'h008, 32'h5000, 38'h2a, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9'h008, 32'h5001, 38'h2b, 1'b1, 1'b0, 1'b1, acc);
      #1;
      check_eq("hold_stall", 64'(o_stall), 64'(1));
      check_eq("hold_addr", 64'(o_addr), 64'(32'h5000));
    end
    step(1'b1, 9'h008, 32'h5001, 38'h2b, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 9'h008, 32'h5002, 38'h2c, 1'b0, 1'b0, 1'b1, acc);
    #1;
    check_eq("pre_reset_cnt", 64'(o_outstanding), 64'(3));

    // Reset mid-burst clears everything; later acks find nothing to count.
    step(1'b0, 9'h000, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    #1;
    check_eq("midrst_valid", 64'(o_valid), 64'(0));
    check_eq("midrst_cnt", 64'(o_outstanding), 64'(0));
    step(1'b0, 9'h000, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    #1;
    check_eq("midrst_ack", 64'(o_outstanding), 64'(0));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      rdec = 9'h100;
      else if (r == 1) rdec = 9'h000;
      else begin
        int k;
        k = int'($urandom_range(0, 2));
        rdec = 9'd1 << ((k == 0) ? 0 : (k == 1) ? 2 : 5);
      end
      rdata = {6'($urandom), $urandom};
      step($urandom_range(0, 9) < 7, rdec, $urandom, rdata,
           ($urandom % 4) == 0, (m_cnt > 0) && (($urandom % 3) == 0),
           ($urandom % 200) != 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
